// File: rtl/e203_soc_lite_pkg.sv
// e203_soc_lite_pkg
//   Shared constants for the SoC glue shell: register offsets, STATUS bit
//   positions, the mtimecmp reset value and byte-mask helpers.
package e203_soc_lite_pkg;

    localparam logic [7:0] OFF_GPIOA_IN  = 8'h00;
    localparam logic [7:0] OFF_GPIOA_OUT = 8'h04;
    localparam logic [7:0] OFF_GPIOA_OE  = 8'h08;
    localparam logic [7:0] OFF_GPIOB_IN  = 8'h0C;
    localparam logic [7:0] OFF_GPIOB_OUT = 8'h10;
    localparam logic [7:0] OFF_GPIOB_OE  = 8'h14;
    localparam logic [7:0] OFF_MSIP      = 8'h18;
    localparam logic [7:0] OFF_MTCMP_LO  = 8'h1C;
    localparam logic [7:0] OFF_MTCMP_HI  = 8'h20;
    localparam logic [7:0] OFF_MTIME_LO  = 8'h24;
    localparam logic [7:0] OFF_MTIME_HI  = 8'h28;
    localparam logic [7:0] OFF_STATUS    = 8'h2C;
    localparam logic [7:0] OFF_GPIOA_IE  = 8'h30;
    localparam logic [7:0] OFF_GPIOA_IP  = 8'h34;

    // STATUS layout: [3:0] latched straps, [4] sticky wake
    localparam int STAT_STRAP_LSB = 0;
    localparam int STAT_WAKE_BIT  = 4;

    localparam logic [63:0] MTIMECMP_RST_DEF = 64'hFFFF_FFFF_FFFF_FFFF;

    // Expand a 4-bit byte enable into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = {8{m[b]}};
        return res;
    endfunction

    // Merge write data into the old value under byte enables
    function automatic logic [31:0] apply_wmask(input logic [31:0] old_v,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  m);
        logic [31:0] bm;
        bm = byte_mask(m);
        return (old_v & ~bm) | (wdata & bm);
    endfunction

endpackage

// File: rtl/e203_soc_lite_sync2.sv
// e203_soc_lite_sync2
//   Two-flop synchronizer for asynchronous pad inputs.
//   i_clk  : sampling clock
//   i_rst  : async active-high reset, both stages clear to 0
//   i_d    : asynchronous input bus
//   o_q    : synchronized output, two cycles of latency
module e203_soc_lite_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/e203_soc_lite_top.sv
// e203_soc_lite_top
//   Pad / always-on glue shell for the E203 SoC.
//   hfextclk, rst          : clock, async active-high reset
//   lfextclk               : slow tick, sampled as data to advance mtime
//   io_pads_gpioA/B_*      : GPIO pads (in value, out value, out enable)
//   io_pads_jtag_*         : unused inputs, TDO tied off
//   io_pads_qspi0_*        : idle QSPI pads (cs high, sck low, dq off)
//   io_pads_aon_pmu_*      : wakeup input, pad power enable, pad reset
//   io_pads_bootrom_n/dbgmode*_n : boot/debug straps latched after reset
//   hfxoscen, lfxoscen     : oscillator enables, always on
//   icb_cmd_* / icb_rsp_*  : single-outstanding register slave
//   ext_irq, sft_irq, tmr_irq : interrupt requests to the core
module e203_soc_lite_top
    import e203_soc_lite_pkg::*;
#(
    parameter int          GPIO_W       = 32,
    parameter int          ADDR_W       = 8,
    parameter logic [63:0] MTIMECMP_RST = MTIMECMP_RST_DEF
) (
    input  logic              hfextclk,
    input  logic              rst,
    input  logic              lfextclk,
    input  logic [GPIO_W-1:0] io_pads_gpioA_i_ival,
    output logic [GPIO_W-1:0] io_pads_gpioA_o_oval,
    output logic [GPIO_W-1:0] io_pads_gpioA_o_oe,
    input  logic [GPIO_W-1:0] io_pads_gpioB_i_ival,
    output logic [GPIO_W-1:0] io_pads_gpioB_o_oval,
    output logic [GPIO_W-1:0] io_pads_gpioB_o_oe,
    input  logic              io_pads_jtag_TCK_i_ival,
    input  logic              io_pads_jtag_TMS_i_ival,
    input  logic              io_pads_jtag_TDI_i_ival,
    output logic              io_pads_jtag_TDO_o_oval,
    output logic              io_pads_jtag_TDO_o_oe,
    output logic              io_pads_qspi0_sck_o_oval,
    output logic              io_pads_qspi0_cs_0_o_oval,
    input  logic              io_pads_qspi0_dq_0_i_ival,
    output logic              io_pads_qspi0_dq_0_o_oval,
    output logic              io_pads_qspi0_dq_0_o_oe,
    input  logic              io_pads_qspi0_dq_1_i_ival,
    output logic              io_pads_qspi0_dq_1_o_oval,
    output logic              io_pads_qspi0_dq_1_o_oe,
    input  logic              io_pads_qspi0_dq_2_i_ival,
    output logic              io_pads_qspi0_dq_2_o_oval,
    output logic              io_pads_qspi0_dq_2_o_oe,
    input  logic              io_pads_qspi0_dq_3_i_ival,
    output logic              io_pads_qspi0_dq_3_o_oval,
    output logic              io_pads_qspi0_dq_3_o_oe,
    input  logic              io_pads_aon_pmu_dwakeup_n_i_ival,
    output logic              io_pads_aon_pmu_vddpaden_o_oval,
    output logic              io_pads_aon_pmu_padrst_o_oval,
    input  logic              io_pads_bootrom_n_i_ival,
    input  logic              io_pads_dbgmode0_n_i_ival,
    input  logic              io_pads_dbgmode1_n_i_ival,
    input  logic              io_pads_dbgmode2_n_i_ival,
    output logic              hfxoscen,
    output logic              lfxoscen,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [31:0]       icb_cmd_wdata,
    input  logic [3:0]        icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [31:0]       icb_rsp_rdata,
    output logic              icb_rsp_err,
    output logic              ext_irq,
    output logic              sft_irq,
    output logic              tmr_irq
);

    // ------------------------------------------------------------ synchronizers
    logic [GPIO_W-1:0] w_gpioa_in;
    logic [GPIO_W-1:0] w_gpiob_in;
    logic              w_lf_sync;
    logic              w_wk_sync;

    e203_soc_lite_sync2 #(.W(GPIO_W)) u_sync_gpioa (
        .i_clk(hfextclk), .i_rst(rst), .i_d(io_pads_gpioA_i_ival), .o_q(w_gpioa_in));
    e203_soc_lite_sync2 #(.W(GPIO_W)) u_sync_gpiob (
        .i_clk(hfextclk), .i_rst(rst), .i_d(io_pads_gpioB_i_ival), .o_q(w_gpiob_in));
    e203_soc_lite_sync2 #(.W(1)) u_sync_lf (
        .i_clk(hfextclk), .i_rst(rst), .i_d(lfextclk), .o_q(w_lf_sync));
    e203_soc_lite_sync2 #(.W(1)) u_sync_wk (
        .i_clk(hfextclk), .i_rst(rst), .i_d(io_pads_aon_pmu_dwakeup_n_i_ival), .o_q(w_wk_sync));

    // ------------------------------------------------------------ registers
    logic [GPIO_W-1:0] r_gpioa_out, r_gpioa_oe, r_gpiob_out, r_gpiob_oe;
    logic [GPIO_W-1:0] r_gpioa_ie, r_gpioa_ip, r_gpioa_prev;
    logic              r_msip;
    logic [63:0]       r_mtimecmp;
    logic [63:0]       r_mtime;
    logic              r_tmr_irq;
    logic [3:0]        r_straps;
    logic              r_strap_done;
    logic              r_wake;
    logic              r_lf_prev;
    logic              r_wk_prev;
    logic [3:0]        r_padrst_cnt;
    logic              r_padrst;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    // ------------------------------------------------------------ decode
    logic        w_acc;
    logic        w_hit;
    logic [31:0] w_cur;
    logic [31:0] w_wval;
    logic [31:0] w_wbits;
    logic        w_wr;

    assign icb_cmd_ready = ~r_rsp_valid | icb_rsp_ready;
    assign w_acc         = icb_cmd_valid & icb_cmd_ready;

    always_comb begin
        w_hit = 1'b1;
        w_cur = 32'h0;
        if (icb_cmd_addr[1:0] != 2'b00) begin
            w_hit = 1'b0;
        end else begin
            case (icb_cmd_addr)
                ADDR_W'(OFF_GPIOA_IN):  w_cur = 32'(w_gpioa_in);
                ADDR_W'(OFF_GPIOA_OUT): w_cur = 32'(r_gpioa_out);
                ADDR_W'(OFF_GPIOA_OE):  w_cur = 32'(r_gpioa_oe);
                ADDR_W'(OFF_GPIOB_IN):  w_cur = 32'(w_gpiob_in);
                ADDR_W'(OFF_GPIOB_OUT): w_cur = 32'(r_gpiob_out);
                ADDR_W'(OFF_GPIOB_OE):  w_cur = 32'(r_gpiob_oe);
                ADDR_W'(OFF_MSIP):      w_cur = {31'h0, r_msip};
                ADDR_W'(OFF_MTCMP_LO):  w_cur = r_mtimecmp[31:0];
                ADDR_W'(OFF_MTCMP_HI):  w_cur = r_mtimecmp[63:32];
                ADDR_W'(OFF_MTIME_LO):  w_cur = r_mtime[31:0];
                ADDR_W'(OFF_MTIME_HI):  w_cur = r_mtime[63:32];
                ADDR_W'(OFF_STATUS):    w_cur = {27'h0, r_wake, r_straps};
                ADDR_W'(OFF_GPIOA_IE):  w_cur = 32'(r_gpioa_ie);
                ADDR_W'(OFF_GPIOA_IP):  w_cur = 32'(r_gpioa_ip);
                default:                w_hit = 1'b0;
            endcase
        end
    end

    assign w_wr    = w_acc & ~icb_cmd_read & w_hit;
    assign w_wval  = apply_wmask(w_cur, icb_cmd_wdata, icb_cmd_wmask);
    // bits written as 1 under the byte enables, for W1C/clear fields
    assign w_wbits = icb_cmd_wdata & byte_mask(icb_cmd_wmask);

    function automatic logic we(input logic wr, input logic [ADDR_W-1:0] a,
                                input logic [7:0] off);
        return wr & (a == ADDR_W'(off));
    endfunction

    // ------------------------------------------------------------ event edges
    logic              w_tick;
    logic              w_wake_edge;
    logic [GPIO_W-1:0] w_ip_set;
    logic              w_mtime_wr;

    assign w_tick      = w_lf_sync & ~r_lf_prev;
    assign w_wake_edge = r_wk_prev & ~w_wk_sync;
    assign w_ip_set    = w_gpioa_in & ~r_gpioa_prev & r_gpioa_ie;
    assign w_mtime_wr  = we(w_wr, icb_cmd_addr, OFF_MTIME_LO) |
                         we(w_wr, icb_cmd_addr, OFF_MTIME_HI);

    // ------------------------------------------------------------ state
    always_ff @(posedge hfextclk or posedge rst) begin
        if (rst) begin
            r_gpioa_out  <= '0;
            r_gpioa_oe   <= '0;
            r_gpiob_out  <= '0;
            r_gpiob_oe   <= '0;
            r_gpioa_ie   <= '0;
            r_gpioa_ip   <= '0;
            r_gpioa_prev <= '0;
            r_msip       <= 1'b0;
            r_mtimecmp   <= MTIMECMP_RST;
            r_mtime      <= 64'h0;
            r_tmr_irq    <= 1'b0;
            r_lf_prev    <= 1'b0;
            r_wk_prev    <= 1'b0;
            r_wake       <= 1'b0;
        end else begin
            r_gpioa_prev <= w_gpioa_in;
            r_lf_prev    <= w_lf_sync;
            r_wk_prev    <= w_wk_sync;
            r_tmr_irq    <= (r_mtime >= r_mtimecmp);

            if (we(w_wr, icb_cmd_addr, OFF_GPIOA_OUT)) r_gpioa_out <= w_wval[GPIO_W-1:0];
            if (we(w_wr, icb_cmd_addr, OFF_GPIOA_OE))  r_gpioa_oe  <= w_wval[GPIO_W-1:0];
            if (we(w_wr, icb_cmd_addr, OFF_GPIOB_OUT)) r_gpiob_out <= w_wval[GPIO_W-1:0];
            if (we(w_wr, icb_cmd_addr, OFF_GPIOB_OE))  r_gpiob_oe  <= w_wval[GPIO_W-1:0];
            if (we(w_wr, icb_cmd_addr, OFF_GPIOA_IE))  r_gpioa_ie  <= w_wval[GPIO_W-1:0];
            if (we(w_wr, icb_cmd_addr, OFF_MSIP))      r_msip      <= w_wval[0];
            if (we(w_wr, icb_cmd_addr, OFF_MTCMP_LO))  r_mtimecmp[31:0]  <= w_wval;
            if (we(w_wr, icb_cmd_addr, OFF_MTCMP_HI))  r_mtimecmp[63:32] <= w_wval;

            // software write beats a same-cycle tick
            if (w_mtime_wr) begin
                if (we(w_wr, icb_cmd_addr, OFF_MTIME_LO)) r_mtime[31:0]  <= w_wval;
                if (we(w_wr, icb_cmd_addr, OFF_MTIME_HI)) r_mtime[63:32] <= w_wval;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            // a same-cycle set beats the W1C
            r_gpioa_ip <= (r_gpioa_ip &
                           ~(we(w_wr, icb_cmd_addr, OFF_GPIOA_IP) ? w_wbits[GPIO_W-1:0]
                                                                   : '0)) | w_ip_set;

            // a same-cycle wake edge beats the clear
            r_wake <= (r_wake & ~(we(w_wr, icb_cmd_addr, OFF_STATUS) & w_wbits[STAT_WAKE_BIT]))
                      | w_wake_edge;
        end
    end

    // Straps are sampled once, on the first clock after reset release
    always_ff @(posedge hfextclk or posedge rst) begin
        if (rst) begin
            r_straps     <= 4'h0;
            r_strap_done <= 1'b0;
        end else if (!r_strap_done) begin
            r_straps     <= {~io_pads_dbgmode2_n_i_ival, ~io_pads_dbgmode1_n_i_ival,
                             ~io_pads_dbgmode0_n_i_ival, ~io_pads_bootrom_n_i_ival};
            r_strap_done <= 1'b1;
        end
    end

    // Pad reset: asserted in reset, then held 16 more cycles while the
    // counter drains from 15 to 0.
    always_ff @(posedge hfextclk or posedge rst) begin
        if (rst) begin
            r_padrst_cnt <= 4'd15;
            r_padrst     <= 1'b1;
        end else begin
            if (r_padrst_cnt != 4'd0) r_padrst_cnt <= r_padrst_cnt - 4'd1;
            r_padrst <= (r_padrst_cnt != 4'd0);
        end
    end

    // Response slot: loaded on accept, drained on rsp_ready
    always_ff @(posedge hfextclk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ~w_hit;
            r_rsp_rdata <= (w_hit & icb_cmd_read) ? w_cur : 32'h0;
        end else if (icb_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------ outputs
    assign icb_rsp_valid = r_rsp_valid;
    assign icb_rsp_rdata = r_rsp_rdata;
    assign icb_rsp_err   = r_rsp_err;

    assign io_pads_gpioA_o_oval = r_gpioa_out;
    assign io_pads_gpioA_o_oe   = r_gpioa_oe;
    assign io_pads_gpioB_o_oval = r_gpiob_out;
    assign io_pads_gpioB_o_oe   = r_gpiob_oe;

    assign ext_irq = |(r_gpioa_ip & r_gpioa_ie);
    assign sft_irq = r_msip;
    assign tmr_irq = r_tmr_irq;

    assign io_pads_aon_pmu_padrst_o_oval   = r_padrst;
    assign io_pads_aon_pmu_vddpaden_o_oval = ~r_padrst;
    assign hfxoscen = 1'b1;
    assign lfxoscen = 1'b1;

    assign io_pads_jtag_TDO_o_oval   = 1'b0;
    assign io_pads_jtag_TDO_o_oe     = 1'b0;
    assign io_pads_qspi0_sck_o_oval  = 1'b0;
    assign io_pads_qspi0_cs_0_o_oval = 1'b1;
    assign io_pads_qspi0_dq_0_o_oval = 1'b0;
    assign io_pads_qspi0_dq_0_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_1_o_oval = 1'b0;
    assign io_pads_qspi0_dq_1_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_2_o_oval = 1'b0;
    assign io_pads_qspi0_dq_2_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_3_o_oval = 1'b0;
    assign io_pads_qspi0_dq_3_o_oe   = 1'b0;

    // Idle pad inputs have no consumer
    logic w_unused;
    assign w_unused = ^{io_pads_jtag_TCK_i_ival, io_pads_jtag_TMS_i_ival,
                        io_pads_jtag_TDI_i_ival, io_pads_qspi0_dq_0_i_ival,
                        io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_2_i_ival,
                        io_pads_qspi0_dq_3_i_ival};

endmodule

// File: tb/tb_e203_soc_lite_top.sv
module tb_e203_soc_lite_top;

    logic        hfextclk = 1'b0;
    logic        rst = 1'b1;
    logic        lfextclk = 1'b0;
    logic [31:0] gpa_i = 32'h0;
    logic [31:0] gpb_i = 32'h0;
    logic        dwk_n = 1'b1;
    logic        icb_cmd_valid = 1'b0;
    logic [7:0]  icb_cmd_addr = 8'h0;
    logic        icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_wdata = 32'h0;
    logic [3:0]  icb_cmd_wmask = 4'h0;
    logic        icb_rsp_ready = 1'b1;

    wire [31:0] gpa_o, gpa_oe, gpb_o, gpb_oe;
    wire        tdo, tdo_oe, sck, cs0;
    wire        dq0, dq0_oe, dq1, dq1_oe, dq2, dq2_oe, dq3, dq3_oe;
    wire        vddpaden, padrst, hfxoscen, lfxoscen;
    wire        icb_cmd_ready, icb_rsp_valid, icb_rsp_err;
    wire [31:0] icb_rsp_rdata;
    wire        ext_irq, sft_irq, tmr_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hfextclk = ~hfextclk;

    e203_soc_lite_top dut (
        .hfextclk(hfextclk), .rst(rst), .lfextclk(lfextclk),
        .io_pads_gpioA_i_ival(gpa_i), .io_pads_gpioA_o_oval(gpa_o), .io_pads_gpioA_o_oe(gpa_oe),
        .io_pads_gpioB_i_ival(gpb_i), .io_pads_gpioB_o_oval(gpb_o), .io_pads_gpioB_o_oe(gpb_oe),
        .io_pads_jtag_TCK_i_ival(1'b0), .io_pads_jtag_TMS_i_ival(1'b0),
        .io_pads_jtag_TDI_i_ival(1'b0),
        .io_pads_jtag_TDO_o_oval(tdo), .io_pads_jtag_TDO_o_oe(tdo_oe),
        .io_pads_qspi0_sck_o_oval(sck), .io_pads_qspi0_cs_0_o_oval(cs0),
        .io_pads_qspi0_dq_0_i_ival(1'b0), .io_pads_qspi0_dq_0_o_oval(dq0), .io_pads_qspi0_dq_0_o_oe(dq0_oe),
        .io_pads_qspi0_dq_1_i_ival(1'b0), .io_pads_qspi0_dq_1_o_oval(dq1), .io_pads_qspi0_dq_1_o_oe(dq1_oe),
        .io_pads_qspi0_dq_2_i_ival(1'b0), .io_pads_qspi0_dq_2_o_oval(dq2), .io_pads_qspi0_dq_2_o_oe(dq2_oe),
        .io_pads_qspi0_dq_3_i_ival(1'b0), .io_pads_qspi0_dq_3_o_oval(dq3), .io_pads_qspi0_dq_3_o_oe(dq3_oe),
        .io_pads_aon_pmu_dwakeup_n_i_ival(dwk_n),
        .io_pads_aon_pmu_vddpaden_o_oval(vddpaden), .io_pads_aon_pmu_padrst_o_oval(padrst),
        .io_pads_bootrom_n_i_ival(1'b0), .io_pads_dbgmode0_n_i_ival(1'b1),
        .io_pads_dbgmode1_n_i_ival(1'b1), .io_pads_dbgmode2_n_i_ival(1'b1),
        .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
        .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge hfextclk);
    endtask

    // One ICB transfer; returns the response sampled on the negedge after accept
    task automatic icb(input logic [7:0] a, input logic rd, input logic [31:0] wd,
                       input logic [3:0] m, output logic [31:0] rdat, output logic err);
        int n;
        @(negedge hfextclk);
        icb_cmd_valid = 1'b1; icb_cmd_addr = a; icb_cmd_read = rd;
        icb_cmd_wdata = wd;   icb_cmd_wmask = m;
        n = 0;
        while (icb_cmd_ready !== 1'b1 && n < 16) begin
            @(negedge hfextclk);
            n++;
        end
        chk("cmd_ready_wait", 64'(n < 16), 64'd1);
        @(posedge hfextclk);
        #1 icb_cmd_valid = 1'b0;
        @(negedge hfextclk);
        chk("rsp_valid", 64'(icb_rsp_valid), 64'd1);
        rdat = icb_rsp_rdata;
        err  = icb_rsp_err;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] rd_d;
        logic        e;
        icb(a, 1'b0, d, m, rd_d, e);
        chk("wr_err", 64'(e), 64'd0);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd_d;
        logic        e;
        icb(a, 1'b1, 32'h0, 4'h0, rd_d, e);
        chk({tag, "_err"}, 64'(e), 64'd0);
        chk(tag, 64'(rd_d), 64'(exp));
    endtask

    task automatic lf_pulse();
        lfextclk = 1'b1; step(4);
        lfextclk = 1'b0; step(4);
    endtask

    initial begin
        logic [31:0] rdat;
        logic        e;

        // ---------------- reset state
        step(3);
        chk("rst_padrst",   64'(padrst),   64'd1);
        chk("rst_vddpaden", 64'(vddpaden), 64'd0);
        chk("rst_tmr_irq",  64'(tmr_irq),  64'd0);
        chk("rst_rsp_valid",64'(icb_rsp_valid), 64'd0);
        chk("qspi_cs",      64'(cs0), 64'd1);
        chk("qspi_sck",     64'(sck), 64'd0);
        chk("qspi_dq_oe",   64'({dq0_oe, dq1_oe, dq2_oe, dq3_oe, tdo_oe}), 64'd0);
        chk("osc_en",       64'({hfxoscen, lfxoscen}), 64'h3);
        chk("rst_gpa_oe",   64'(gpa_oe), 64'd0);
        rst = 1'b0;

        // ---------------- pad reset stretch: 16 cycles after release
        repeat (15) @(posedge hfextclk);
        #1 chk("padrst_c15", 64'(padrst), 64'd1);
        @(posedge hfextclk);
        #1 chk("padrst_c16",   64'(padrst),   64'd0);
        chk("vddpaden_on", 64'(vddpaden), 64'd1);

        // ---------------- straps
        rd("status_straps", 8'h2C, 32'h1);

        // ---------------- GPIO A out / oe with byte mask
        wr(8'h04, 32'hA5A5_1234, 4'b1100);
        wr(8'h08, 32'hFFFF_FFFF, 4'hF);
        chk("gpa_oval", 64'(gpa_o),  64'hA5A5_0000);
        chk("gpa_oe",   64'(gpa_oe), 64'hFFFF_FFFF);
        rd("gpa_out_rd", 8'h04, 32'hA5A5_0000);

        // ---------------- GPIO input synchronizer latency
        gpa_i = 32'h3;
        rd("gpa_in_early", 8'h00, 32'h0);
        rd("gpa_in_late",  8'h00, 32'h3);
        wr(8'h00, 32'hFFFF_FFFF, 4'hF);        // RO write, no error
        rd("gpa_in_ro", 8'h00, 32'h3);

        // ---------------- GPIO interrupt
        wr(8'h30, 32'h1, 4'hF);
        chk("ext_irq_idle", 64'(ext_irq), 64'd0);
        gpa_i = 32'h2; step(4);
        gpa_i = 32'h3; step(4);
        chk("ext_irq_set", 64'(ext_irq), 64'd1);
        rd("gpa_ip", 8'h34, 32'h1);
        wr(8'h34, 32'h1, 4'hF);
        chk("ext_irq_clr", 64'(ext_irq), 64'd0);

        // ---------------- machine timer
        wr(8'h24, 32'h0, 4'hF);
        wr(8'h28, 32'h0, 4'hF);
        wr(8'h1C, 32'h3, 4'hF);
        wr(8'h20, 32'h0, 4'hF);
        step(2);
        chk("tmr_irq_0", 64'(tmr_irq), 64'd0);
        lf_pulse(); lf_pulse();
        chk("tmr_irq_2ticks", 64'(tmr_irq), 64'd0);
        lf_pulse();
        chk("tmr_irq_3ticks", 64'(tmr_irq), 64'd1);
        rd("mtime_lo", 8'h24, 32'h3);
        rd("mtime_hi", 8'h28, 32'h0);
        wr(8'h20, 32'hFFFF_FFFF, 4'hF);
        step(1);
        chk("tmr_irq_off", 64'(tmr_irq), 64'd0);

        // mtime wraps from all-ones to zero
        wr(8'h24, 32'hFFFF_FFFF, 4'hF);
        wr(8'h28, 32'hFFFF_FFFF, 4'hF);
        lf_pulse();
        rd("mtime_wrap_lo", 8'h24, 32'h0);
        rd("mtime_wrap_hi", 8'h28, 32'h0);

        // ---------------- software interrupt
        wr(8'h18, 32'h1, 4'hF);
        chk("sft_irq", 64'(sft_irq), 64'd1);

        // ---------------- error responses
        icb(8'h05, 1'b1, 32'h0, 4'h0, rdat, e);
        chk("misalign_err",   64'(e),    64'd1);
        chk("misalign_rdata", 64'(rdat), 64'd0);
        icb(8'h3C, 1'b0, 32'hDEAD_BEEF, 4'hF, rdat, e);
        chk("unmapped_wr_err", 64'(e), 64'd1);

        // ---------------- response stall with rsp_ready low
        @(negedge hfextclk);
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_addr = 8'h3C; icb_cmd_read = 1'b1;
        @(posedge hfextclk);
        #1 icb_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge hfextclk);
            chk("stall_valid", 64'(icb_rsp_valid), 64'd1);
            chk("stall_err",   64'(icb_rsp_err),   64'd1);
            chk("stall_rdata", 64'(icb_rsp_rdata), 64'd0);
            chk("stall_ready", 64'(icb_cmd_ready), 64'd0);
        end
        icb_rsp_ready = 1'b1;
        #1 chk("unstall_ready", 64'(icb_cmd_ready), 64'd1);
        @(negedge hfextclk);
        chk("rsp_drained", 64'(icb_rsp_valid), 64'd0);

        // ---------------- back-to-back: write then read GPIOB_OUT
        @(negedge hfextclk);
        icb_cmd_valid = 1'b1; icb_cmd_addr = 8'h10; icb_cmd_read = 1'b0;
        icb_cmd_wdata = 32'h1111_2222; icb_cmd_wmask = 4'hF;
        @(posedge hfextclk);
        #1 icb_cmd_read = 1'b1;
        @(negedge hfextclk);
        chk("b2b_ready", 64'(icb_cmd_ready), 64'd1);
        @(posedge hfextclk);
        #1 icb_cmd_valid = 1'b0;
        @(negedge hfextclk);
        chk("b2b_rsp_valid", 64'(icb_rsp_valid), 64'd1);
        chk("b2b_rdata",     64'(icb_rsp_rdata), 64'h1111_2222);
        chk("gpb_oval",      64'(gpb_o),         64'h1111_2222);

        // ---------------- wakeup sticky bit
        dwk_n = 1'b0; step(4);
        dwk_n = 1'b1; step(4);
        rd("status_wake", 8'h2C, 32'h11);
        wr(8'h2C, 32'h10, 4'hF);
        rd("status_wake_clr", 8'h2C, 32'h01);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/e203_soc_lite_top.md
Name: e203_soc_lite_top

Overview:
Chip-level pad/always-on glue shell for the E203 SoC. It owns the GPIO A/B pads, idle QSPI0 and JTAG pads, the PMU pad outputs, boot/debug strap capture, an lfextclk-driven machine timer and a software-interrupt bit. It exposes a single-outstanding ICB-style register slave to the CPU subsystem, which is instantiated alongside it, and drives that subsystem's ext/sft/tmr interrupt lines.

Parameters:
GPIO_W, 32, width of each GPIO bank
ADDR_W, 8, register offset width (byte address, word aligned)
MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, mtimecmp reset value (timer IRQ off)

Ports:
hfextclk  in  1  sole clock; all flops on rising edge
rst  in  1  async active-high reset; replaces the erst_n pad
lfextclk  in  1  32.768 kHz-class tick input, sampled as data only
io_pads_gpioA_i_ival / io_pads_gpioB_i_ival  in  GPIO_W  pad inputs
io_pads_gpioA_o_oval, _o_oe / io_pads_gpioB_o_oval, _o_oe  out  GPIO_W  pad out value / enable
io_pads_jtag_TCK/TMS/TDI_i_ival  in  1 each  unused
io_pads_jtag_TDO_o_oval, io_pads_jtag_TDO_o_oe  out  1 each  tied 0
io_pads_qspi0_sck_o_oval, io_pads_qspi0_cs_0_o_oval  out  1 each  idle 0 / 1
io_pads_qspi0_dq_N_i_ival (N=0..3)  in  1  unused
io_pads_qspi0_dq_N_o_oval, _o_oe (N=0..3)  out  1  tied 0
io_pads_aon_pmu_dwakeup_n_i_ival  in  1  active-low wakeup pad
io_pads_aon_pmu_vddpaden_o_oval, io_pads_aon_pmu_padrst_o_oval  out  1 each  pad power enable / pad reset
io_pads_bootrom_n_i_ival, io_pads_dbgmode0/1/2_n_i_ival  in  1 each  straps
hfxoscen, lfxoscen  out  1 each  oscillator enables, constant 1
icb_cmd_valid  in  1; icb_cmd_ready  out  1; icb_cmd_addr  in  ADDR_W; icb_cmd_read  in  1; icb_cmd_wdata  in  32; icb_cmd_wmask  in  4
icb_rsp_valid  out  1; icb_rsp_ready  in  1; icb_rsp_rdata  out  32; icb_rsp_err  out  1
ext_irq, sft_irq, tmr_irq  out  1 each  interrupt requests to the core

Behaviour:
- Reset: all registers 0 except mtimecmp=MTIMECMP_RST; the pad-reset stretch counter is loaded with 15.
- padrst = 1 while rst is asserted and for 16 cycles after release; vddpaden = ~padrst. hfxoscen = lfxoscen = 1 (combinational).
- Straps: on the first cycle after reset release, latch status = {~dbgmode2_n, ~dbgmode1_n, ~dbgmode0_n, ~bootrom_n}; held until the next reset.
- Synchronizers: GPIO inputs, lfextclk and dwakeup_n each pass through 2 flops. A 0->1 edge of synced lfextclk increments the 64-bit mtime by 1, wrapping at 2^64-1 -> 0. A 1->0 edge of synced dwakeup_n sets the sticky wake bit.
- Interrupts: tmr_irq = (mtime >= mtimecmp), unsigned, registered. sft_irq = msip[0]. A rising edge on synced GPIOA bit i with ie[i]=1 sets ip[i]. ext_irq = |(ip & ie).
- Register map (32-bit, wmask byte enables):
  0x00 GPIOA_IN (RO), 0x04 GPIOA_OUT, 0x08 GPIOA_OE
  0x0C GPIOB_IN (RO), 0x10 GPIOB_OUT, 0x14 GPIOB_OE
  0x18 MSIP (bit0), 0x1C MTIMECMP_LO, 0x20 MTIMECMP_HI
  0x24 MTIME_LO, 0x28 MTIME_HI (writable)
  0x2C STATUS (RO: [3:0] straps, [4] wake; writing 1 to bit4 clears wake)
  0x30 GPIOA_IE, 0x34 GPIOA_IP (W1C)
- Pad outputs are driven directly from the OUT/OE registers.
- Unmapped offset or misaligned addr[1:0]!=0: rsp_err=1, rdata=0, no state change. Writes to RO registers are ignored with no error.
- Handshake: icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready. A command is accepted on valid&ready; the response is registered and valid the next cycle, then held stable until rsp_ready. Back-to-back commands give one per cycle when rsp_ready=1.
- Simultaneous events: a software write to MTIME wins over a tick increment; a W1C on IP loses to a same-cycle set (the bit stays 1); a wake-clear loses to a same-cycle wake edge.
- Reset asserted mid-transaction: rsp_valid drops immediately and the transaction is lost.

Decomposition:
- Package e203_soc_lite_pkg: register offset constants, STATUS bit positions, MTIMECMP_RST.
- One sub-module e203_soc_lite_sync2 (2-flop synchronizer, parameterised width), reused for the GPIO, lfextclk and wakeup inputs. Everything else stays in the top.

Test Plan:
- Reset with straps bootrom_n=0, dbgmode*_n=1 -> padrst=1 for 16 cycles after release then vddpaden=1; read 0x2C = 0x1; QSPI cs=1, sck=0, dq oe=0; tmr_irq=0.
- Write 0x04=0xA5A5_0000 with wmask=4'b1100, then 0x08=0xFFFF_FFFF -> gpioA_o_oval=0xA5A5_0000, oe all-ones; read 0x04 returns 0xA5A5_0000.
- Drive gpioA_i=0x3 -> read 0x00 returns 0x3 no earlier than 2 cycles later; set IE=0x1 and toggle bit0 0->1 -> ext_irq=1; write 0x34=0x1 -> ext_irq=0.
- Write MTIME=0 and MTIMECMP=3 (HI=0), apply 3 lfextclk rising edges -> tmr_irq=1; write MTIMECMP_HI=0xFFFF_FFFF -> tmr_irq=0.
- Write MSIP=1 -> sft_irq=1; read 0x3C -> rsp_err=1, rdata=0; hold rsp_ready=0 for 3 cycles -> icb_cmd_ready=0 and rsp held stable.
- Pulse dwakeup_n low -> STATUS bit4=1; write 0x2C=0x10 -> bit4=0.
